de_coder_cmd_queue: RTL and testbench

//   Downstream stage of the decoder command producer. Captures one command word on each

---
 rtl/de_coder_cmd_queue.sv | 118 +++++++++++
 tb/tb_de_coder_cmd_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/de_coder_cmd_queue.sv
// de_coder_cmd_queue: first-word-fall-through command FIFO between the decoder
// command producer and the DSP execute unit. It detects the END opcode, stops
// accepting new writes, drains the queued commands, and then pulses done.
// Optional build macro: DE_CODER_CMDQ_STATS_EN adds the accept_cnt and
// drop_cnt saturating statistics outputs.
module de_coder_cmd_queue #(
  parameter int              CMD_W      = 16,
  parameter int              OP_W       = 4,
  parameter int              DEPTH_LOG2 = 3,
  parameter logic [OP_W-1:0] END_OP     = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [CMD_W-1:0]      cmd_in,
  output logic [CMD_W-1:0]      cmd_out,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
`ifdef DE_CODER_CMDQ_STATS_EN
  output logic [15:0]           accept_cnt,
  output logic [15:0]           drop_cnt,
`endif
  output logic                  end_seen,
  output logic                  overflow,
  output logic                  done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CMD_W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count_nxt;
  logic                    push, pop, drop, is_end, done_nxt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_valid = !empty && (state != DONE);
  assign cmd_out   = mem[rd_ptr];
  assign is_end    = (cmd_in[CMD_W-1 -: OP_W] == END_OP);

  assign pop  = cmd_valid && cmd_ready;
  // A write into a full queue is only accepted if a pop frees a slot this cycle.
  assign push = wr && (state == RUN) && (!full || pop);
  // Writes in DRAIN/DONE are ignored rather than dropped, so they are not counted here.
  assign drop = wr && (state == RUN) && full && !pop;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Program-completion FSM: next state and the one-cycle done pulse.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      RUN:     if (push && is_end) state_nxt = DRAIN;
      DRAIN:   if (count_nxt == '0) begin
                 state_nxt = DONE;
                 done_nxt  = 1'b1;
               end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Storage array; its contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Pointers, occupancy, state and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= RUN;
      end_seen <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      state <= state_nxt;
      done  <= done_nxt;
      if (push && is_end) end_seen <= 1'b1;
      if (drop)           overflow <= 1'b1;
    end
  end

`ifdef DE_CODER_CMDQ_STATS_EN
  // Saturating counters of accepted and dropped writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push && accept_cnt != 16'hFFFF) accept_cnt <= accept_cnt + 1'b1;
      if (drop && drop_cnt != 16'hFFFF)   drop_cnt   <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_de_coder_cmd_queue.sv
// Directed self-checking bench for de_coder_cmd_queue (default parameters).
module tb_de_coder_cmd_queue;
  logic        clk = 1'b0;
  logic        reset, wr, cmd_ready;
  logic [15:0] cmd_in, cmd_out;
  logic        cmd_valid, full, empty, end_seen, overflow, done;
  logic [3:0]  count;
`ifdef DE_CODER_CMDQ_STATS_EN
  logic [15:0] accept_cnt, drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] q[$];

  de_coder_cmd_queue dut (
    .clk(clk), .reset(reset), .wr(wr), .cmd_in(cmd_in), .cmd_out(cmd_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .full(full), .empty(empty),
    .count(count),
`ifdef DE_CODER_CMDQ_STATS_EN
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt),
`endif
    .end_seen(end_seen), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; cmd_ready = 1'b0; cmd_in = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic write(input logic [15:0] d);
    wr = 1'b1; cmd_in = d;
    step();
    wr = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_end_seen", end_seen, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);

    // Three writes, then stream them out with ready held high.
    write(16'h1001); write(16'h1002); write(16'h1003);
    chk("basic_count", count, 3);
    chk("basic_head", cmd_out, 16'h1001);
    chk("basic_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("basic_pop%0d", i), cmd_out, 16'h1000 + 16'(i));
      step();
    end
    chk("basic_empty", empty, 1);
    chk("basic_valid0", cmd_valid, 0);
    cmd_ready = 1'b0;

    // Fill to depth 8, then one more write is dropped.
    do_reset();
    for (int i = 0; i < 8; i++) write(16'h2000 + 16'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf0", overflow, 0);
    write(16'h2008);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 8);
    chk("drop_head", cmd_out, 16'h2000);
`ifdef DE_CODER_CMDQ_STATS_EN
    chk("stat_accept", accept_cnt, 8);
    chk("stat_drop", drop_cnt, 1);
`endif

    // Full queue with simultaneous write and pop.
    do_reset();
    for (int i = 0; i < 8; i++) write(16'h3000 + 16'(i));
    wr = 1'b1; cmd_in = 16'h3AAA; cmd_ready = 1'b1;
    step();
    wr = 1'b0;
    chk("fullpp_count", count, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", cmd_out, 16'h3001);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("fullpp_pop%0d", i), cmd_out, 16'h3000 + 16'(i));
      step();
    end
    chk("fullpp_last", cmd_out, 16'h3AAA);
    step();
    chk("fullpp_empty", empty, 1);
    cmd_ready = 1'b0;

    // END handling, drain and done pulse.
    do_reset();
    write(16'h1234);
    chk("end_pre", end_seen, 0);
    write(16'hF000);
    chk("end_seen", end_seen, 1);
    write(16'h2222);
    chk("end_ignored_cnt", count, 2);
    chk("end_ignored_ovf", overflow, 0);
    cmd_ready = 1'b1;
    chk("end_pop1", cmd_out, 16'h1234);
    step();
    chk("end_pop2", cmd_out, 16'hF000);
    chk("end_done0", done, 0);
    step();
    chk("end_done1", done, 1);
    chk("end_valid0", cmd_valid, 0);
    chk("end_empty", empty, 1);
    step();
    chk("end_done_pulse", done, 0);
    cmd_ready = 1'b0;

    // Pointer wrap: 20 writes with pops on three of every four cycles.
    do_reset();
    q.delete();
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; cmd_in = 16'h5000 + 16'(i);
      cmd_ready = (i % 4) != 1;
      if (q.size() != 0 && cmd_ready) begin
        chk("wrap_out", cmd_out, q[0]);
        void'(q.pop_front());
      end
      q.push_back(cmd_in);
      step();
    end
    wr = 1'b0; cmd_ready = 1'b1;
    chk("wrap_count", count, q.size());
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      chk("wrap_drain", cmd_out, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("wrap_left", q.size(), 0);
    chk("wrap_empty", empty, 1);
    cmd_ready = 1'b0;

    // Reset while draining with five entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) write(16'h6000 + 16'(i));
    write(16'hF001);
    chk("drain_count5", count, 5);
    chk("drain_end", end_seen, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("drst_count", count, 0);
    chk("drst_empty", empty, 1);
    chk("drst_end", end_seen, 0);
    write(16'h7777);
    chk("drst_run", count, 1);
    chk("drst_head", cmd_out, 16'h7777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
